mult_seq_shiftadd: RTL
======================

// Module: mult_seq_shiftadd
// PURPOSE
//   Parametrised sequential shift-add multiplier; successor to the 4x4 combinational multiplier.
//   Scales a channel sample (a) by a volume/envelope factor (b) using one adder iterated over B_WIDTH cycles.
//   Optionally treats a as two's-complement.
//   Sits between the tone/noise channel mixer and the output DAC path.
//   Valid/ready on both sides, so it can be time-shared across channels.
// PARAMETERS
//   A_WIDTH   4  width of multiplicand a (sample)
//   B_WIDTH   4  width of multiplier b (volume, always unsigned); also the iteration count
//   SIGNED_A  0  1: a is two's-complement and y is signed; 0: a is unsigned
// PORTS
//   clk        in   1                  clock, all state on rising edge
//   rst        in   1                  synchronous reset, active-high
//   in_valid   in   1                  operands a/b present
//   in_ready   out  1                  block can accept operands this cycle
//   a          in   A_WIDTH            multiplicand
//   b          in   B_WIDTH            multiplier
//   out_valid  out  1                  y holds a finished product
//   out_ready  in   1                  consumer accepts y this cycle
//   y          out  A_WIDTH+B_WIDTH    product a*b
//   busy       out  1                  high while iterating (BUSY state)
// BEHAVIOUR
// - Reset:
//   - rst high at an edge forces IDLE, acc=0, y=0, out_valid=0, busy=0, count=0.
//   - Reset mid-operation discards the product; no partial result is ever presented.
// - States:
//   - IDLE: in_ready=1.
//   - BUSY: in_ready=0, busy=1.
//   - DONE: out_valid=1, in_ready=out_ready.
// - IDLE -> BUSY on in_valid&in_ready:
//   - latch a, extended to A_WIDTH+B_WIDTH (sign-extended if SIGNED_A=1, else zero-extended);
//   - latch b; acc=0; count=0.
// - BUSY, one step per cycle:
//   - if b_reg[count] then acc += a_ext<<count (modulo 2^(A_WIDTH+B_WIDTH));
//   - count++.
//   - After the step with count=B_WIDTH-1: go to DONE, and y <= final acc.
// - Latency: accept at edge T -> out_valid=1 and y valid from edge T+B_WIDTH.
//   - Defaults: 4 cycles.
//   - No early termination, even when b=0.
// - DONE -> IDLE on out_ready with in_valid low.
//   - y is held stable while out_valid=1 and out_ready=0 (backpressure, indefinitely).
// - DONE with out_ready&in_valid on the same edge:
//   - output is consumed and the new operands are accepted;
//   - go straight to BUSY; out_valid drops the next cycle.
//   - Back-to-back throughput: one product per B_WIDTH+1 cycles.
// - in_valid while in BUSY (in_ready=0): ignored; the source must hold the operands.
//   - Operand changes during BUSY have no effect on the current product.
// - Width rule:
//   - full product fits A_WIDTH+B_WIDTH bits in both modes, so no overflow is possible;
//   - SIGNED_A=1 with b=2^B_WIDTH-1 and a=min negative must give the exact negative product.
// - y keeps its last value after the handshake; it is only meaningful while out_valid=1.
// - in_ready, out_valid and busy are registered-state decodes; no combinational path from in_valid.
// TESTING (defaults unless stated)
//   1. Reset, then a=15 b=15 with out_ready=1 -> out_valid exactly 4 cycles after accept, y=8'd225, then IDLE.
//   2. Exhaustive 16x16 unsigned sweep, random out_ready stalls -> every y==a*b, y stable while stalled, no drops or dups.
//   3. SIGNED_A=1: a=4'b1000 (-8) b=15 -> y=8'h88 (-120); a=4'b0111 b=15 -> y=8'd105; a=-1 b=0 -> y=0.
//   4. rst asserted 2 cycles into BUSY (a=9 b=7) -> next cycle IDLE, out_valid=0, y=0; a following op a=3 b=5 -> y=15.
//   5. Back-to-back: in_valid held high, out_ready=1 -> accepts on the DONE-cycle handshake, one result per 5 cycles.
//      Also: operands changed during BUSY are ignored.
//   6. A_WIDTH=8 B_WIDTH=6 SIGNED_A=1, a=-128 b=63 -> y=14'h2080 (-8064) after 6 cycles; random compare vs $signed model.

Source files
------------

// File: rtl/mult_seq_shiftadd.sv
// Sequential shift-add multiplier: one adder iterated over B_WIDTH cycles,
// valid/ready on both sides, optional two's-complement multiplicand.
module mult_seq_shiftadd #(
   parameter int A_WIDTH  = 4,
   parameter int B_WIDTH  = 4,
   parameter bit SIGNED_A = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [A_WIDTH-1:0]         a,
   input  logic [B_WIDTH-1:0]         b,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [A_WIDTH+B_WIDTH-1:0] y,
   output logic                       busy
);

   localparam int P_WIDTH = A_WIDTH + B_WIDTH;
   localparam int CW      = (B_WIDTH > 1) ? $clog2(B_WIDTH) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(B_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_reg, state_next;
   logic [P_WIDTH-1:0]   a_ext_reg, a_ext_next;
   logic [B_WIDTH-1:0]   b_reg, b_next;
   logic [P_WIDTH-1:0]   acc_reg, acc_next;
   logic [CW-1:0]        count_reg, count_next;
   logic [P_WIDTH-1:0]   y_reg, y_next;

   logic [P_WIDTH-1:0]   a_ext_in;
   logic [P_WIDTH-1:0]   pp [B_WIDTH];
   logic [P_WIDTH-1:0]   step_sum;

   // Widening to the full product width up front makes the modulo-2^P sum exact
   // in both modes, including the most negative multiplicand.
   generate
      if (SIGNED_A) begin : g_sext
         assign a_ext_in = {{B_WIDTH{a[A_WIDTH-1]}}, a};
      end else begin : g_zext
         assign a_ext_in = {{B_WIDTH{1'b0}}, a};
      end
   endgenerate

   // One gated, pre-shifted partial product per multiplier bit; the step picks one.
   genvar gi;
   generate
      for (gi = 0; gi < B_WIDTH; gi++) begin : g_pp
         assign pp[gi] = b_reg[gi] ? (a_ext_reg << gi) : '0;
      end
   endgenerate

   assign step_sum = acc_reg + pp[count_reg];

   always_comb begin
      state_next = state_reg;
      a_ext_next = a_ext_reg;
      b_next     = b_reg;
      acc_next   = acc_reg;
      count_next = count_reg;
      y_next     = y_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;

      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_ext_next = a_ext_in;
               b_next     = b;
               acc_next   = '0;
               count_next = '0;
               state_next = BUSY;
            end
         end
         BUSY: begin
            busy       = 1'b1;
            acc_next   = step_sum;
            count_next = count_reg + 1'b1;
            if (count_reg == LAST_STEP) begin
               y_next     = step_sum;
               count_next = '0;
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            // Output handshake and a new accept can share one edge.
            if (out_ready) begin
               if (in_valid) begin
                  a_ext_next = a_ext_in;
                  b_next     = b;
                  acc_next   = '0;
                  count_next = '0;
                  state_next = BUSY;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         a_ext_reg <= '0;
         b_reg     <= '0;
         acc_reg   <= '0;
         count_reg <= '0;
         y_reg     <= '0;
      end else begin
         state_reg <= state_next;
         a_ext_reg <= a_ext_next;
         b_reg     <= b_next;
         acc_reg   <= acc_next;
         count_reg <= count_next;
         y_reg     <= y_next;
      end
   end

   assign y = y_reg;

endmodule
